// File: rtl/cp0_pkg.sv
// CP0 shared constants: register addresses, ExcCodes, field positions, write masks, reset values.
// Pure declarations, no logic; imported by the CP0 control block and its bench-facing consumers.
package cp0_pkg;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic [4:0] ADDR_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int CAUSE_EXC_LSB  = 2;
  localparam int CAUSE_IP_LSB   = 8;
  localparam int CAUSE_HWIP_LSB = 10;
  localparam int CAUSE_TI_BIT   = 30;
  localparam int CAUSE_BD_BIT   = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam logic [31:0] REG_RST    = 32'h0000_0000;

  // Address-error exceptions are the only ones that latch BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines.
// Latency 2 clk edges; no backpressure, level signals only.
module cp0_int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      dout   <= '0;
    end else begin
      meta_q <= din;
      dout   <= meta_q;
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 register block: Count/Compare timer, Status, Cause, EPC, BadVAddr, PRId, Config.
// Writes and exception/eret commits visible the cycle after the edge; reads are combinational; never stalls.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM     = 6,
  parameter int          TIMER_IRQ_LINE = 5,
  parameter int          COUNT_DIV      = 2,
  parameter logic [31:0] PRID_VAL       = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL     = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           data_o,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           data_i,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o,
  output logic                  int_pending_o
);

  logic [HW_INT_NUM-1:0] int_sync;
  logic [31:0] count_q, compare_q, status_q, epc_q, badvaddr_q, cause_sw_q;
  logic [4:0]  presc_q, exccode_q;
  logic        ti_q, bd_q;
  logic [5:0]  ip_hw;
  logic        presc_wrap, wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  cp0_int_sync #(.WIDTH(HW_INT_NUM)) u_int_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (int_i),
    .dout (int_sync)
  );

  assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign wr_status  = we_i && (waddr_i == ADDR_STATUS);
  assign wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
  assign wr_epc     = we_i && (waddr_i == ADDR_EPC);
  assign presc_wrap = (presc_q == 5'(COUNT_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= REG_RST;
      presc_q <= '0;
    end else if (wr_count) begin
      count_q <= data_i;
      presc_q <= '0;
    end else if (presc_wrap) begin
      count_q <= count_q + 32'd1;
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 5'd1;
    end
  end

  // Compare write wins over a coincident match so software can always acknowledge the timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= REG_RST;
      ti_q      <= 1'b0;
    end else begin
      if ((count_q == compare_q) && (compare_q != 32'd0))
        ti_q <= 1'b1;
      if (wr_compare) begin
        compare_q <= data_i;
        ti_q      <= 1'b0;
      end
    end
  end

  // Later assignments take precedence: exception over eret over mtc0 on shared fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_sw_q <= REG_RST;
      epc_q      <= REG_RST;
      badvaddr_q <= REG_RST;
      bd_q       <= 1'b0;
      exccode_q  <= 5'd0;
    end else begin
      if (wr_status) status_q   <= data_i & STATUS_WMASK;
      if (wr_cause)  cause_sw_q <= data_i & CAUSE_WMASK;
      if (wr_epc)    epc_q      <= data_i;
      if (exc_valid_i) begin
        status_q[STATUS_EXL_BIT] <= 1'b1;
        exccode_q                <= exc_code_i;
        if (!status_q[STATUS_EXL_BIT]) begin
          epc_q <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
          bd_q  <= exc_bd_i;
        end
        if (is_addr_exc(exc_code_i))
          badvaddr_q <= exc_badvaddr_i;
      end else if (eret_i) begin
        status_q[STATUS_EXL_BIT] <= 1'b0;
      end
    end
  end

  always_comb begin
    ip_hw = '0;
    for (int k = 0; k < HW_INT_NUM; k++)
      ip_hw[k] = int_sync[k];
    ip_hw[TIMER_IRQ_LINE] = ip_hw[TIMER_IRQ_LINE] | ti_q;
  end

  assign cause_o = cause_sw_q | {bd_q, ti_q, 14'd0, ip_hw, 3'd0, exccode_q, 2'd0};
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign epc_o       = epc_q;
  assign timer_int_o = ti_q;
  assign int_pending_o = (|(status_q[15:8] & cause_o[15:8])) & status_q[STATUS_IE_BIT]
                         & ~status_q[STATUS_EXL_BIT];

  always_comb begin
    case (raddr_i)
      ADDR_BADVADDR: data_o = badvaddr_q;
      ADDR_COUNT:    data_o = count_q;
      ADDR_COMPARE:  data_o = compare_q;
      ADDR_STATUS:   data_o = status_q;
      ADDR_CAUSE:    data_o = cause_o;
      ADDR_EPC:      data_o = epc_q;
      ADDR_PRID:     data_o = PRID_VAL;
      ADDR_CONFIG:   data_o = CONFIG_VAL;
      default:       data_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: register map, timer, exceptions, interrupts, precedence and async reset.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] exc_badvaddr_i;
  logic        eret_i;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
  logic        timer_int_o, int_pending_o;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_ctrl dut (
    .clk(clk), .rst(rst), .raddr_i(raddr_i), .data_o(data_o),
    .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i), .int_i(int_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .exc_bd_i(exc_bd_i), .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i),
    .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .timer_int_o(timer_int_o),
    .int_pending_o(int_pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    raddr_i = a;
    #1;
    check(tag, data_o, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic [31:0] bva);
    exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc; exc_bd_i = bd; exc_badvaddr_i = bva;
    @(negedge clk);
    exc_valid_i = 1'b0;
  endtask

  task automatic eret();
    eret_i = 1'b1;
    @(negedge clk);
    eret_i = 1'b0;
  endtask

  logic [4:0]  rd_addr [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd20, 5'd0};
  logic [31:0] rd_exp  [10] = '{32'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h0, 32'h0,
                                32'h004C_0102, 32'h0000_8000, 32'h0, 32'h0};

  initial begin
    rst = 1'b1; raddr_i = '0; we_i = 1'b0; waddr_i = '0; data_i = '0; int_i = '0;
    exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0; exc_bd_i = 1'b0;
    exc_badvaddr_i = '0; eret_i = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_timer", {31'd0, timer_int_o}, 32'd0);
    check("rst_pend", {31'd0, int_pending_o}, 32'd0);
    for (int i = 0; i < 10; i++)
      rd(rd_addr[i], rd_exp[i], $sformatf("rst_rd_%0d", rd_addr[i]));
    @(negedge clk);
    rst = 1'b0;

    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 32'h1000_FF03, "status_mask");
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h00C0_0300, "cause_mask");
    wr(5'd12, 32'h1000_0000);
    wr(5'd13, 32'h0);
    wr(5'd20, 32'h1234_5678);
    rd(5'd20, 32'h0, "unmapped_wr");

    wr(5'd9, 32'd0);
    check("count_w0", count_o, 32'd0);
    repeat (2) @(negedge clk);
    check("count_2e", count_o, 32'd1);
    repeat (2) @(negedge clk);
    check("count_4e", count_o, 32'd2);

    wr(5'd11, 32'd10);
    for (int i = 0; i < 100; i++) begin
      if (timer_int_o) break;
      @(negedge clk);
    end
    check("ti_set", {31'd0, timer_int_o}, 32'd1);
    check("ti_count", count_o, 32'd10);
    check("ti_cause", cause_o, 32'h4000_8000);
    repeat (6) @(negedge clk);
    check("ti_sticky", {31'd0, timer_int_o}, 32'd1);
    check("ti_count13", count_o, 32'd13);
    wr(5'd12, 32'h1000_8001);
    check("ti_pend", {31'd0, int_pending_o}, 32'd1);
    wr(5'd11, 32'd0);
    check("ti_clr", {31'd0, timer_int_o}, 32'd0);
    check("ti_pend_clr", {31'd0, int_pending_o}, 32'd0);

    wr(5'd12, 32'h1000_0000);
    exc(5'd4, 32'h100, 1'b1, 32'h203);
    check("exc1_epc", epc_o, 32'hFC);
    check("exc1_cause", cause_o, 32'h8000_0010);
    check("exc1_status", status_o, 32'h1000_0002);
    rd(5'd8, 32'h203, "exc1_bva");
    exc(5'd8, 32'h300, 1'b0, 32'h999);
    check("exc2_epc", epc_o, 32'hFC);
    check("exc2_cause", cause_o, 32'h8000_0020);
    rd(5'd8, 32'h203, "exc2_bva");

    eret();
    check("eret_status", status_o, 32'h1000_0000);
    wr(5'd12, 32'h1000_1001);
    int_i = 6'b000100;
    @(negedge clk);
    check("int_1edge", {31'd0, int_pending_o}, 32'd0);
    @(negedge clk);
    check("int_cause", cause_o, 32'h8000_1020);
    check("int_pend", {31'd0, int_pending_o}, 32'd1);
    wr(5'd12, 32'h1000_1003);
    check("int_exl", {31'd0, int_pending_o}, 32'd0);
    eret();
    check("int_eret", {31'd0, int_pending_o}, 32'd1);

    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hDEAD_0000;
    exc(5'd0, 32'h500, 1'b0, 32'h0);
    we_i = 1'b0;
    check("prec_epc", epc_o, 32'h500);
    check("prec_status", status_o, 32'h1000_1003);
    eret();
    eret_i = 1'b1;
    exc(5'd12, 32'h600, 1'b0, 32'h0);
    eret_i = 1'b0;
    check("prec_eret", status_o, 32'h1000_1003);
    check("prec_eret_epc", epc_o, 32'h600);
    check("prec_eret_cause", cause_o, 32'h0000_1030);

    wr(5'd9, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    check("count_wrap", count_o, 32'd0);

    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", count_o, 32'd0);
    check("arst_status", status_o, 32'h1000_0000);
    check("arst_pend", {31'd0, int_pending_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
